showahead_sync_fifo: RTL and testbench

Single-clock, show-ahead (first-word-fall-through) FIFO with occupancy count and programmable almost-full/almost-empty flags. It is a drop-in replacement for the vendor single-clock FIFO configured with show-ahead on, overflow/underflow checking on and read-while-full off. Cycle behaviour of every flag matches that configuration so the two can run in lock-step.

---
 rtl/showahead_sync_fifo_if.sv | 25 ++
 rtl/showahead_sync_fifo.sv | 81 ++++++++
 tb/tb_showahead_sync_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/showahead_sync_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and the show-ahead FIFO (slave).
interface showahead_sync_fifo_if #(
    parameter int DWIDTH = 4,
    parameter int AWIDTH = 16
);
    logic [DWIDTH-1:0] data_i;
    logic              wrreq_i;
    logic              rdreq_i;
    logic [DWIDTH-1:0] q_o;
    logic              empty_o;
    logic              full_o;
    logic [AWIDTH:0]   usedw_o;
    logic              almost_full_o;
    logic              almost_empty_o;

    modport master (
        output data_i, wrreq_i, rdreq_i,
        input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o
    );

    modport slave (
        input  data_i, wrreq_i, rdreq_i,
        output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o
    );
endinterface

// File: rtl/showahead_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered count and almost flags;
// a write while full is dropped even when a read is accepted in the same cycle.
module showahead_sync_fifo #(
    parameter int DWIDTH             = 4,
    parameter int AWIDTH             = 16,
    parameter int ALMOST_FULL_VALUE  = 10,
    parameter int ALMOST_EMPTY_VALUE = 3
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    showahead_sync_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0]   CNT_AF   = (AWIDTH + 1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0]   CNT_AE   = (AWIDTH + 1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [AWIDTH:0]   count, count_next;
    logic [DWIDTH-1:0] q_reg, q_next;
    logic              empty_reg, full_reg, af_reg, ae_reg;
    logic              wr_acc, rd_acc;

    assign wr_acc = bus.wrreq_i && !full_reg;
    assign rd_acc = bus.rdreq_i && !empty_reg;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next  = count;
        rd_ptr_next = rd_ptr;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
        if (rd_acc)
            rd_ptr_next = rd_ptr + PTR_ONE;
        // The head word is being written this very edge (empty FIFO, or last word consumed
        // while writing), so it must bypass the memory to be valid when empty_o falls.
        q_next = (wr_acc && (wr_ptr == rd_ptr_next)) ? bus.data_i : mem[rd_ptr_next];
    end

    // NOTE: storage has no reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            af_reg    <= 1'b0;
            ae_reg    <= 1'b1;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            q_reg     <= q_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CNT_FULL);
            af_reg    <= (count_next >= CNT_AF);
            ae_reg    <= (count_next < CNT_AE);
        end
    end

    assign bus.q_o            = q_reg;
    assign bus.empty_o        = empty_reg;
    assign bus.full_o         = full_reg;
    assign bus.usedw_o        = count;
    assign bus.almost_full_o  = af_reg;
    assign bus.almost_empty_o = ae_reg;
endmodule

// File: tb/tb_showahead_sync_fifo.sv
// Directed plus random traffic against a count model and a FIFO-order scoreboard, checked every cycle.
module tb_showahead_sync_fifo;
    localparam int DW  = 4;
    localparam int AW  = 4;
    localparam int AFV = 10;
    localparam int AEV = 3;
    localparam int DEP = 2 ** AW;

    logic clk    = 1'b0;
    logic srst_n = 1'b1;

    showahead_sync_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    showahead_sync_fifo #(
        .DWIDTH(DW), .AWIDTH(AW),
        .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
    ) dut (
        .clk_i (clk),
        .srst_i(srst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int m_cnt      = 0;
    logic [DW-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive requests, advance the model, then compare every output after the edge.
    task automatic cycle(input logic rst_n, input logic w, input logic r, input logic [DW-1:0] d);
        logic wa, ra;
        srst_n      = rst_n;
        bus.wrreq_i = w;
        bus.rdreq_i = r;
        bus.data_i  = d;
        wa = w && (m_cnt != DEP);
        ra = r && (m_cnt != 0);
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0;
            sb.delete();
        end else begin
            if (ra) void'(sb.pop_front());
            if (wa) sb.push_back(d);
            m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        end
        #1;
        check("usedw", 32'(bus.usedw_o), 32'(m_cnt));
        check("empty", 32'(bus.empty_o), 32'(m_cnt == 0));
        check("full", 32'(bus.full_o), 32'(m_cnt == DEP));
        check("almost_full", 32'(bus.almost_full_o), 32'(m_cnt >= AFV));
        check("almost_empty", 32'(bus.almost_empty_o), 32'(m_cnt < AEV));
        if (m_cnt != 0)
            check("q", 32'(bus.q_o), 32'(sb[0]));
        srst_n      = 1'b1;
        bus.wrreq_i = 1'b0;
        bus.rdreq_i = 1'b0;
    endtask

    initial begin
        int written;
        int budget;
        logic w, r;
        int wp, rp;

        bus.data_i  = '0;
        bus.wrreq_i = 1'b0;
        bus.rdreq_i = 1'b0;

        // Reset, then idle with reads on an empty FIFO.
        cycle(1'b0, 1'b1, 1'b1, 4'h5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 4'h0);

        // Single word through an empty FIFO.
        cycle(1'b1, 1'b1, 1'b0, 4'hA);
        check("q_after_first_write", 32'(bus.q_o), 32'h0000000A);
        cycle(1'b1, 1'b0, 1'b1, 4'h0);

        // Ten words, watch the almost flags, read back in order.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 4'h0);

        // Fill to full, then write+read together: the write must be dropped.
        for (int i = 0; i < DEP; i++) cycle(1'b1, 1'b1, 1'b0, DW'(i));
        check("full_at_depth", 32'(bus.full_o), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 4'hF);
        check("usedw_after_rw_full", 32'(bus.usedw_o), 32'd15);
        for (int i = 0; i < DEP - 1; i++) cycle(1'b1, 1'b0, 1'b1, 4'h0);

        // Random traffic, 1000 words, biased by the almost flags.
        written = 0;
        budget  = 0;
        while ((written < 1000 || m_cnt != 0) && budget < 20000) begin
            if (m_cnt < AEV) begin
                wp = 75; rp = 25;
            end else if (m_cnt >= AFV) begin
                wp = 25; rp = 75;
            end else begin
                wp = 50; rp = 50;
            end
            w = (written < 1000) && ($urandom_range(99) < wp);
            r = (written >= 1000) || ($urandom_range(99) < rp);
            if (w && m_cnt != DEP) written++;
            cycle(1'b1, w, r, DW'($urandom_range(15)));
            budget++;
        end
        check("random_completed_in_budget", 32'(budget < 20000), 32'd1);

        // Reset with five words stored drops them all.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, DW'(i + 3));
        cycle(1'b0, 1'b0, 1'b0, 4'h0);
        check("usedw_after_reset", 32'(bus.usedw_o), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'h7);
        check("q_new_word_after_reset", 32'(bus.q_o), 32'h00000007);
        cycle(1'b1, 1'b0, 1'b1, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
